// File: rtl/ex_pkg.sv
// Shared definitions for the execute pipe: ALU operation codes, operand
// select encodings, FSM state type and a small op classification helper.
package ex_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_PASSB  = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

  localparam logic [1:0] ASEL_A    = 2'd0;
  localparam logic [1:0] ASEL_PC   = 2'd1;
  localparam logic [1:0] ASEL_ZERO = 2'd2;

  localparam logic [1:0] BSEL_B    = 2'd0;
  localparam logic [1:0] BSEL_IMM  = 2'd1;
  localparam logic [1:0] BSEL_FOUR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide engine operating on operand magnitudes.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   kill_i          abandon any operation in progress
//   start_i, op_i   launch op_i (MUL..REMU) with operands a_i, b_i
//   done_o          high for the one cycle in which the result is finalised
//   res_o           sign-corrected result, valid from the cycle after done_o
// Timing: start edge loads operands, XLEN step edges follow, then done_o is
// high for one cycle and the next edge writes res_o.
import ex_pkg::*;

module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill_i,
  input  logic            start_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] res_o
);

  localparam int CW = $clog2(XLEN) + 1;

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, a_q, a_d, res_q, res_d;
  logic [4:0]      op_q, op_d;
  logic            negq_q, negq_d, negr_q, negr_d, bz_q, bz_d;

  logic            sa, sb, is_div;
  logic [XLEN:0]   sum, sh;
  logic [2*XLEN-1:0] prod, prodc;
  logic [XLEN-1:0] quot, rem;

  assign done_o = busy_q && (cnt_q == CW'(XLEN));
  assign res_o  = res_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    a_d    = a_q;
    op_d   = op_q;
    negq_d = negq_q;
    negr_d = negr_q;
    bz_d   = bz_q;
    res_d  = res_q;
    sa     = 1'b0;
    sb     = 1'b0;
    sum    = '0;
    sh     = '0;
    prod   = '0;
    prodc  = '0;
    quot   = '0;
    rem    = '0;
    is_div = (op_q >= OP_DIV);

    if (kill_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      // Operand signedness depends on the op; MULHSU treats only op1 as signed.
      sa = ((op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
            (op_i == OP_DIV) || (op_i == OP_REM)) && a_i[XLEN-1];
      sb = ((op_i == OP_MUL) || (op_i == OP_MULH) ||
            (op_i == OP_DIV) || (op_i == OP_REM)) && b_i[XLEN-1];
      busy_d = 1'b1;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = sa ? -a_i : a_i;
      b_d    = sb ? -b_i : b_i;
      a_d    = a_i;
      op_d   = op_i;
      negq_d = sa ^ sb;
      negr_d = sa;
      bz_d   = (b_i == '0);
    end else if (busy_q) begin
      if (cnt_q == CW'(XLEN)) begin
        busy_d = 1'b0;
        prod   = {hi_q, lo_q};
        prodc  = negq_q ? -prod : prod;
        quot   = negq_q ? -lo_q : lo_q;
        rem    = negr_q ? -hi_q : hi_q;
        case (op_q)
          OP_MUL:                       res_d = prodc[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: res_d = prodc[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU:              res_d = bz_q ? '1 : quot;
          default:                      res_d = bz_q ? a_q : rem;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (is_div) begin
          // Restoring division: hi holds the partial remainder, lo shifts the
          // dividend out and the quotient bits in.
          sh = {hi_q, lo_q[XLEN-1]};
          if (sh >= {1'b0, b_q}) begin
            hi_d = sh[XLEN-1:0] - b_q;
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          // Shift-add multiply: lo holds the multiplier, product grows into hi.
          sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
          hi_d = sum[XLEN:1];
          lo_d = {sum[0], lo_q[XLEN-1:1]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      a_q    <= '0;
      op_q   <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      bz_q   <= 1'b0;
      res_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      a_q    <= a_d;
      op_q   <= op_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      bz_q   <= bz_d;
      res_q  <= res_d;
    end
  end

endmodule

// File: rtl/ex_pipe.sv
// Execute stage: operand select, single-cycle ALU, branch compare and an
// iterative multiply/divide unit behind a registered valid/ready output.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush                  kill in-flight/held result, return to IDLE
//   in_valid/in_ready      upstream handshake
//   DataA, DataB, pc, imm  operand sources; ASel/BSel pick op1/op2
//   BrUn, ALUop            compare signedness, operation code
//   out_valid/out_ready    downstream handshake
//   ALU_out, BrEq, BrLT    registered result and compare flags
//   state_o                current FSM state (debug)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; a producer holds valid and its payload stable until that edge.
import ex_pkg::*;

module ex_pipe #(
  parameter int XLEN = 32,
  parameter int M_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] DataA,
  input  logic [XLEN-1:0] DataB,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [1:0]      ASel,
  input  logic [1:0]      BSel,
  input  logic            BrUn,
  input  logic [4:0]      ALUop,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALU_out,
  output logic            BrEq,
  output logic            BrLT,
  output logic [1:0]      state_o
);

  localparam int SW = $clog2(XLEN);

  state_t          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] alu_out_q, alu_out_d;
  logic            breq_q, breq_d, brlt_q, brlt_d;
  logic            peq_q, peq_d, plt_q, plt_d;  // flags held while BUSY

  logic [XLEN-1:0] op1, op2, alu_res, md_res;
  logic [SW-1:0]   shamt;
  logic            br_eq, br_lt, mc, accept, md_done;

  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept    = in_valid && in_ready;
  assign mc        = (M_EN != 0) && is_muldiv(ALUop);
  assign out_valid = out_valid_q;
  assign ALU_out   = alu_out_q;
  assign BrEq      = breq_q;
  assign BrLT      = brlt_q;
  assign state_o   = state_q;
  assign shamt     = op2[SW-1:0];
  assign br_eq     = (DataA == DataB);
  assign br_lt     = BrUn ? (DataA < DataB) : ($signed(DataA) < $signed(DataB));

  always_comb begin
    op1 = '0;
    case (ASel)
      ASEL_A:  op1 = DataA;
      ASEL_PC: op1 = pc;
      default: op1 = '0;
    endcase
    op2 = '0;
    case (BSel)
      BSEL_B:    op2 = DataB;
      BSEL_IMM:  op2 = imm;
      BSEL_FOUR: op2 = XLEN'(4);
      default:   op2 = '0;
    endcase
  end

  // Mul/div codes fall to the default (zero) when handled here, which is the
  // required single-cycle result when the M extension is disabled.
  always_comb begin
    alu_res = '0;
    case (ALUop)
      OP_ADD:   alu_res = op1 + op2;
      OP_SUB:   alu_res = op1 - op2;
      OP_SLL:   alu_res = op1 << shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      OP_XOR:   alu_res = op1 ^ op2;
      OP_SRL:   alu_res = op1 >> shamt;
      OP_SRA:   alu_res = $signed(op1) >>> shamt;
      OP_OR:    alu_res = op1 | op2;
      OP_AND:   alu_res = op1 & op2;
      OP_PASSB: alu_res = op2;
      default:  alu_res = '0;
    endcase
  end

  ex_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .kill_i  (flush),
    .start_i (accept && mc),
    .op_i    (ALUop),
    .a_i     (op1),
    .b_i     (op2),
    .done_o  (md_done),
    .res_o   (md_res)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    breq_d      = breq_q;
    brlt_d      = brlt_q;
    peq_d       = peq_q;
    plt_d       = plt_q;
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (out_valid_q && out_ready) out_valid_d = 1'b0;
          if (accept) begin
            if (mc) begin
              state_d     = ST_BUSY;
              peq_d       = br_eq;
              plt_d       = br_lt;
              out_valid_d = 1'b0;
            end else begin
              alu_out_d   = alu_res;
              breq_d      = br_eq;
              brlt_d      = br_lt;
              out_valid_d = 1'b1;
            end
          end
        end
        ST_BUSY: if (md_done) state_d = ST_DONE;
        ST_DONE: begin
          alu_out_d   = md_res;
          breq_d      = peq_q;
          brlt_d      = plt_q;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      breq_q      <= 1'b0;
      brlt_q      <= 1'b0;
      peq_q       <= 1'b0;
      plt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      breq_q      <= breq_d;
      brlt_q      <= brlt_d;
      peq_q       <= peq_d;
      plt_q       <= plt_d;
    end
  end

endmodule
